// File: rtl/vga_scan.sv
// vga_scan: pixel-clock divider, horizontal/vertical scan counters and a
// registered compositing/sync output stage with one pixel of latency.
module vga_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        is_kid,
  input  logic [11:0] kid_rgb,
  input  logic [11:0] bg_rgb,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        hs,
  output logic        vs,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_hs;
  logic             r_vs;
  logic [11:0]      r_rgb;
  logic             r_frame_tick;

  logic             w_pix_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hs_n;
  logic             w_vs_n;
  logic [11:0]      w_rgb;

  assign col        = r_h;
  assign row        = r_v;
  assign pix_tick   = w_pix_tick;
  assign frame_tick = r_frame_tick;
  assign hs         = r_hs;
  assign vs         = r_vs;
  assign vga_rgb    = r_rgb;

  // Decode pixel strobe, wrap points, active window, sync windows and colour.
  always_comb begin
    w_pix_tick = (r_div == DIV_LAST);
    w_h_last   = (r_h == H_LAST);
    w_v_last   = (r_v == V_LAST);
    w_active   = (r_h < H_ACT) && (r_v < V_ACT);
    w_hs_n     = !((r_h >= HS_BEGIN) && (r_h < HS_END));
    w_vs_n     = !((r_v >= VS_BEGIN) && (r_v < VS_END));
    w_rgb      = '0;
    if (w_active) begin
      w_rgb = is_kid ? kid_rgb : bg_rgb;
    end
  end

  // Clock divider: counts 0..CLK_DIV-1 and wraps on the pixel strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div <= '0;
    end else if (w_pix_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Scan counters: h advances per pixel, v advances when h wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Output stage: colour and syncs captured together on the pixel strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (w_pix_tick) begin
      r_rgb <= w_rgb;
      r_hs  <= w_hs_n;
      r_vs  <= w_vs_n;
    end
  end

  // End-of-frame pulse, one clk wide, on the strobe leaving the last pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_pix_tick && w_h_last && w_v_last;
    end
  end

endmodule
